// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32 load/store unit: operation and size encodings,
// memory-stage FSM states, exception causes and the alignment rule.
package rv32_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_STORE = 2'd2,
      OP_RSVD  = 2'd3
   } lsu_op_t;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_t;

   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

   // Natural alignment: the low log2(size) address bits must be zero.
   function automatic logic is_misaligned(lsu_size_t size, logic [2:0] addr_lo);
      case (size)
         SZ_H:    return addr_lo[0];
         SZ_W:    return |addr_lo[1:0];
         SZ_D:    return |addr_lo;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_stage_align.sv
// Combinational lane logic: store data replication and byte enables, and load data
// extraction with sign/zero extension, for an XLEN-wide naturally aligned bus.
module lsu_align
   import rv32_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]                 size,
   input  logic [$clog2(XLEN/8)-1:0]  offset,
   input  logic                       ld_unsigned,
   input  logic [XLEN-1:0]            st_data,
   input  logic [XLEN-1:0]            ld_data,
   output logic [XLEN/8-1:0]          be,
   output logic [XLEN-1:0]            st_wdata,
   output logic [XLEN-1:0]            ld_result
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   logic [NB-1:0]    be_mask;
   logic [XLEN-1:0]  shifted;
   logic [XLEN-1:0]  low_mask;
   logic             sign_bit;
   logic [OFF_W+2:0] shamt;

   assign shamt = {offset, 3'b000};

   // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      be_mask  = '1;
      st_wdata = st_data;
      low_mask = '1;
      sign_bit = 1'b0;
      shifted  = ld_data >> shamt;
      case (lsu_size_t'(size))
         SZ_B: begin
            be_mask  = NB'(1);
            st_wdata = {NB{st_data[7:0]}};
            low_mask = XLEN'(64'hFF);
            sign_bit = shifted[7];
         end
         SZ_H: begin
            be_mask  = NB'(3);
            st_wdata = {(XLEN/16){st_data[15:0]}};
            low_mask = XLEN'(64'hFFFF);
            sign_bit = shifted[15];
         end
         SZ_W: begin
            be_mask  = NB'(15);
            st_wdata = {(XLEN/32){st_data[31:0]}};
            low_mask = XLEN'(64'hFFFF_FFFF);
            sign_bit = shifted[31];
         end
         default: ;
      endcase
      be        = be_mask << offset;
      ld_result = (shifted & low_mask) | ((sign_bit && !ld_unsigned) ? ~low_mask : '0);
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: accepts one instruction per handshake, runs the dmem
// request/grant/response protocol and emits a registered write-back packet.
module lsu_mem_stage
   import rv32_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_mem_op,
   input  logic [1:0]          in_size,
   input  logic                in_unsigned,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [XLEN-1:0]     in_wdata,
   input  logic [XLEN-1:0]     in_wb_data,
   input  logic                in_wb_en,
   input  logic [4:0]          in_rd,
   input  logic [31:0]         in_pc,
   output logic                dmem_req,
   input  logic                dmem_gnt,
   output logic                dmem_we,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic [XLEN/8-1:0]   dmem_be,
   output logic [XLEN-1:0]     dmem_wdata,
   input  logic                dmem_rvalid,
   input  logic [XLEN-1:0]     dmem_rdata,
   output logic                wb_valid,
   output logic                wb_enable,
   output logic [4:0]          wb_addr,
   output logic [XLEN-1:0]     wb_data,
   output logic [31:0]         wb_pc,
   output logic                exc_valid,
   output logic [3:0]          exc_cause,
   output logic [ADDR_W-1:0]   exc_tval,
   output logic                stall
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   lsu_state_t       state;
   lsu_size_t        r_size;
   logic             r_unsigned;
   logic [OFF_W-1:0] r_off;

   lsu_op_t          op;
   logic             misaligned;
   logic             illegal;
   logic [1:0]       al_size;
   logic [OFF_W-1:0] al_off;
   logic [NB-1:0]    al_be;
   logic [XLEN-1:0]  al_wdata;
   logic [XLEN-1:0]  al_ld;

   assign in_ready   = (state == ST_IDLE);
   assign stall      = !in_ready;
   assign op         = lsu_op_t'(in_mem_op);
   assign misaligned = is_misaligned(lsu_size_t'(in_size), in_addr[2:0]);
   assign illegal    = (XLEN == 32) && (lsu_size_t'(in_size) == SZ_D);

   // The aligner serves the incoming store in IDLE and the captured load afterwards.
   assign al_size = in_ready ? in_size : r_size;
   assign al_off  = in_ready ? in_addr[OFF_W-1:0] : r_off;

   lsu_align #(.XLEN(XLEN)) u_align (
      .size        (al_size),
      .offset      (al_off),
      .ld_unsigned (r_unsigned),
      .st_data     (in_wdata),
      .ld_data     (dmem_rdata),
      .be          (al_be),
      .st_wdata    (al_wdata),
      .ld_result   (al_ld)
   );

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         r_size     <= SZ_B;
         r_unsigned <= 1'b0;
         r_off      <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
         wb_valid   <= 1'b0;
         wb_enable  <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         wb_pc      <= '0;
         exc_valid  <= 1'b0;
         exc_cause  <= '0;
         exc_tval   <= '0;
      end else begin
         wb_valid  <= 1'b0;
         exc_valid <= 1'b0;
         case (state)
            ST_IDLE: if (in_valid) begin
               wb_addr    <= in_rd;
               wb_pc      <= in_pc;
               r_size     <= lsu_size_t'(in_size);
               r_unsigned <= in_unsigned;
               r_off      <= in_addr[OFF_W-1:0];
               if (op == OP_NONE || op == OP_RSVD) begin
                  wb_valid  <= 1'b1;
                  wb_enable <= in_wb_en;
                  wb_data   <= in_wb_data;
               end else if (illegal || misaligned) begin
                  wb_valid  <= 1'b1;
                  wb_enable <= 1'b0;
                  wb_data   <= '0;
                  exc_valid <= 1'b1;
                  exc_tval  <= in_addr;
                  if (op == OP_LOAD) exc_cause <= illegal ? CAUSE_LD_FAULT : CAUSE_LD_MISALIGN;
                  else               exc_cause <= illegal ? CAUSE_ST_FAULT : CAUSE_ST_MISALIGN;
               end else begin
                  state      <= ST_REQ;
                  dmem_req   <= 1'b1;
                  dmem_we    <= (op == OP_STORE);
                  dmem_addr  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                  dmem_be    <= al_be;
                  dmem_wdata <= al_wdata;
               end
            end
            ST_REQ: if (dmem_gnt) begin
               dmem_req <= 1'b0;
               if (dmem_we) begin
                  wb_valid  <= 1'b1;
                  wb_enable <= 1'b0;
                  wb_data   <= '0;
                  state     <= ST_IDLE;
               end else begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: if (dmem_rvalid) begin
               wb_valid  <= 1'b1;
               wb_enable <= (wb_addr != 5'd0);
               wb_data   <= al_ld;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed table-driven bench for lsu_mem_stage: XLEN=32 vectors plus hand-written
// back-to-back, reset-during-response and XLEN=64 double-load sequences.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0, in_ready, in_unsigned = 1'b0, in_wb_en = 1'b0;
   logic [1:0]  in_mem_op = '0, in_size = '0;
   logic [31:0] in_addr = '0, in_wdata = '0, in_wb_data = '0, in_pc = '0;
   logic [4:0]  in_rd = '0;
   logic        dmem_req, dmem_gnt = 1'b0, dmem_we, dmem_rvalid = 1'b0;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
   logic [3:0]  dmem_be;
   logic        wb_valid, wb_enable, exc_valid, stall;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data, wb_pc, exc_tval;
   logic [3:0]  exc_cause;

   logic        q_in_valid = 1'b0, q_in_ready, q_dmem_req, q_dmem_gnt = 1'b0, q_dmem_we;
   logic        q_dmem_rvalid = 1'b0, q_wb_valid, q_wb_enable, q_exc_valid, q_stall;
   logic [31:0] q_in_addr = '0, q_dmem_addr, q_exc_tval, q_wb_pc;
   logic [63:0] q_dmem_wdata, q_dmem_rdata = '0, q_wb_data;
   logic [7:0]  q_dmem_be;
   logic [4:0]  q_wb_addr;
   logic [3:0]  q_exc_cause;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_mem_stage #(.XLEN(32), .ADDR_W(32)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .in_mem_op(in_mem_op), .in_size(in_size), .in_unsigned(in_unsigned),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_wb_data(in_wb_data),
      .in_wb_en(in_wb_en), .in_rd(in_rd), .in_pc(in_pc),
      .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_enable(wb_enable), .wb_addr(wb_addr),
      .wb_data(wb_data), .wb_pc(wb_pc), .exc_valid(exc_valid),
      .exc_cause(exc_cause), .exc_tval(exc_tval), .stall(stall)
   );

   lsu_mem_stage #(.XLEN(64), .ADDR_W(32)) dut64 (
      .clk(clk), .resetn(resetn), .in_valid(q_in_valid), .in_ready(q_in_ready),
      .in_mem_op(2'd1), .in_size(2'd3), .in_unsigned(1'b0),
      .in_addr(q_in_addr), .in_wdata(64'h0), .in_wb_data(64'h0),
      .in_wb_en(1'b0), .in_rd(5'd10), .in_pc(32'h200),
      .dmem_req(q_dmem_req), .dmem_gnt(q_dmem_gnt), .dmem_we(q_dmem_we),
      .dmem_addr(q_dmem_addr), .dmem_be(q_dmem_be), .dmem_wdata(q_dmem_wdata),
      .dmem_rvalid(q_dmem_rvalid), .dmem_rdata(q_dmem_rdata),
      .wb_valid(q_wb_valid), .wb_enable(q_wb_enable), .wb_addr(q_wb_addr),
      .wb_data(q_wb_data), .wb_pc(q_wb_pc), .exc_valid(q_exc_valid),
      .exc_cause(q_exc_cause), .exc_tval(q_exc_tval), .stall(q_stall)
   );

   typedef struct {
      int          op;
      int          size;
      int          uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] alu;
      int          wben;
      int          rd;
      int          gd;       // cycles of dmem_req before gnt
      int          rvd;      // cycles in RESP before rvalid
      logic [31:0] rdata;
      int          e_req;
      logic [3:0]  e_be;
      logic [31:0] e_dwdata;
      logic [31:0] e_daddr;
      int          e_wben;
      logic [31:0] e_data;
      int          e_chk;    // compare wb_data
      int          e_exc;
      int          e_cause;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0] pc;
      pc = 32'h100 + 32'(idx * 4);
      @(negedge clk);
      check("ready_before_accept", in_ready, 1);
      in_valid    = 1'b1;
      in_mem_op   = 2'(v.op);
      in_size     = 2'(v.size);
      in_unsigned = 1'(v.uns);
      in_addr     = v.addr;
      in_wdata    = v.wdata;
      in_wb_data  = v.alu;
      in_wb_en    = 1'(v.wben);
      in_rd       = 5'(v.rd);
      in_pc       = pc;
      @(negedge clk);
      in_valid = 1'b0;
      if (v.e_req != 0) begin
         for (int c = 0; c <= v.gd; c++) begin
            check("req_high", dmem_req, 1);
            check("req_addr", dmem_addr, v.e_daddr);
            check("req_be", dmem_be, v.e_be);
            check("req_we", dmem_we, (v.op == 2) ? 1 : 0);
            if (v.op == 2) check("req_wdata", dmem_wdata, v.e_dwdata);
            check("stall_req", stall, 1);
            check("no_wb_req", wb_valid, 0);
            if (c == v.gd) dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt = 1'b0;
         end
         if (v.op == 1) begin
            for (int c = 0; c <= v.rvd; c++) begin
               check("req_dropped", dmem_req, 0);
               check("stall_resp", stall, 1);
               check("no_wb_resp", wb_valid, 0);
               if (c == v.rvd) begin
                  dmem_rvalid = 1'b1;
                  dmem_rdata  = v.rdata;
               end
               @(negedge clk);
               dmem_rvalid = 1'b0;
            end
         end
      end else begin
         check("no_req", dmem_req, 0);
      end
      check("wb_valid", wb_valid, 1);
      check("ready_at_retire", in_ready, 1);
      check("wb_enable", wb_enable, v.e_wben);
      check("wb_addr", wb_addr, v.rd);
      check("wb_pc", wb_pc, pc);
      check("exc_valid", exc_valid, v.e_exc);
      if (v.e_exc != 0) begin
         check("exc_cause", exc_cause, v.e_cause);
         check("exc_tval", exc_tval, v.addr);
      end
      if (v.e_chk != 0) check("wb_data", wb_data, v.e_data);
      @(negedge clk);
      check("wb_pulse_once", wb_valid, 0);
   endtask

   initial begin
      // op size uns addr wdata alu wben rd gd rvd rdata | req be dwdata daddr wben data chk exc cause
      vecs[0]  = '{2, 0, 0, 32'h1003, 32'hAB, 32'h0, 0, 5, 0, 0, 32'h0,
                   1, 4'b1000, 32'hABABABAB, 32'h1000, 0, 32'h0, 0, 0, 0};
      vecs[1]  = '{1, 0, 0, 32'h1003, 32'h0, 32'h0, 0, 7, 0, 0, 32'hAB000000,
                   1, 4'b1000, 32'h0, 32'h1000, 1, 32'hFFFFFFAB, 1, 0, 0};
      vecs[2]  = '{1, 1, 1, 32'h1002, 32'h0, 32'h0, 0, 9, 1, 1, 32'h80010000,
                   1, 4'b1100, 32'h0, 32'h1000, 1, 32'h00008001, 1, 0, 0};
      vecs[3]  = '{1, 2, 0, 32'h1001, 32'h0, 32'h0, 0, 4, 0, 0, 32'h0,
                   0, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 1, 4};
      vecs[4]  = '{1, 2, 0, 32'h2000, 32'h0, 32'h0, 0, 3, 3, 2, 32'hDEADBEEF,
                   1, 4'b1111, 32'h0, 32'h2000, 1, 32'hDEADBEEF, 1, 0, 0};
      vecs[5]  = '{2, 3, 0, 32'h10, 32'h55, 32'h0, 0, 1, 0, 0, 32'h0,
                   0, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 1, 7};
      vecs[6]  = '{2, 1, 0, 32'h1001, 32'h1234, 32'h0, 0, 1, 0, 0, 32'h0,
                   0, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 1, 6};
      vecs[7]  = '{1, 1, 0, 32'h1000, 32'h0, 32'h0, 0, 2, 0, 1, 32'h12348765,
                   1, 4'b0011, 32'h0, 32'h1000, 1, 32'hFFFF8765, 1, 0, 0};
      vecs[8]  = '{1, 0, 1, 32'h1001, 32'h0, 32'h0, 0, 0, 1, 0, 32'h00005A00,
                   1, 4'b0010, 32'h0, 32'h1000, 0, 32'h0, 0, 0, 0};
      vecs[9]  = '{0, 2, 0, 32'h0, 32'h0, 32'hCAFEF00D, 1, 12, 0, 0, 32'h0,
                   0, 4'b0000, 32'h0, 32'h0, 1, 32'hCAFEF00D, 1, 0, 0};
      vecs[10] = '{1, 3, 0, 32'h20, 32'h0, 32'h0, 0, 4, 0, 0, 32'h0,
                   0, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 1, 1, 5};
      vecs[11] = '{2, 2, 0, 32'h3004, 32'h11223344, 32'h0, 0, 6, 2, 0, 32'h0,
                   1, 4'b1111, 32'h11223344, 32'h3004, 0, 32'h0, 0, 0, 0};
      vecs[12] = '{3, 0, 0, 32'h0, 32'h0, 32'h77, 0, 8, 0, 0, 32'h0,
                   0, 4'b0000, 32'h0, 32'h0, 0, 32'h77, 1, 0, 0};
      vecs[13] = '{2, 1, 0, 32'h2, 32'hBEEF, 32'h0, 0, 1, 0, 0, 32'h0,
                   1, 4'b1100, 32'hBEEFBEEF, 32'h0, 0, 32'h0, 0, 0, 0};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_dmem_req", dmem_req, 0);
      check("rst_dmem_be", dmem_be, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_data", wb_data, 0);
      check("rst_exc_valid", exc_valid, 0);
      check("rst_q_in_ready", q_in_ready, 1);
      resetn = 1'b1;

      for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

      // Back-to-back non-memory ops retire one per cycle
      @(negedge clk);
      in_valid = 1'b1; in_mem_op = 2'd0; in_wb_en = 1'b1;
      in_rd = 5'd1; in_wb_data = 32'hA; in_pc = 32'h400;
      @(negedge clk);
      in_rd = 5'd2; in_wb_data = 32'hB; in_pc = 32'h404;
      check("b2b_wb0_valid", wb_valid, 1);
      check("b2b_wb0_data", wb_data, 32'hA);
      check("b2b_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("b2b_wb1_valid", wb_valid, 1);
      check("b2b_wb1_data", wb_data, 32'hB);
      check("b2b_wb1_addr", wb_addr, 2);

      // Reset while waiting in RESP; a late rvalid must be dropped
      @(negedge clk);
      in_valid = 1'b1; in_mem_op = 2'd1; in_size = 2'd2; in_addr = 32'h40; in_rd = 5'd3;
      @(negedge clk);
      in_valid = 1'b0;
      check("rr_req", dmem_req, 1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      check("rr_in_resp", stall, 1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check("rr_ready", in_ready, 1);
      check("rr_req_low", dmem_req, 0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      check("rr_no_wb", wb_valid, 0);
      @(negedge clk);
      check("rr_no_wb_late", wb_valid, 0);
      check("rr_ready_late", in_ready, 1);

      // XLEN=64 double load, zero-wait memory: retire at T+3
      @(negedge clk);
      q_in_valid = 1'b1; q_in_addr = 32'h8;
      @(negedge clk);
      q_in_valid = 1'b0;
      check("d64_req", q_dmem_req, 1);
      check("d64_be", q_dmem_be, 8'hFF);
      check("d64_addr", q_dmem_addr, 32'h8);
      check("d64_stall_t1", q_in_ready, 0);
      q_dmem_gnt = 1'b1;
      @(negedge clk);
      q_dmem_gnt = 1'b0;
      check("d64_stall_t2", q_in_ready, 0);
      q_dmem_rvalid = 1'b1; q_dmem_rdata = 64'h0123456789ABCDEF;
      @(negedge clk);
      q_dmem_rvalid = 1'b0;
      check("d64_wb_valid", q_wb_valid, 1);
      check("d64_wb_data", q_wb_data, 64'h0123456789ABCDEF);
      check("d64_wb_enable", q_wb_enable, 1);
      check("d64_ready_t3", q_in_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Parametrised load/store memory stage for the in-order single-issue core, sitting between execute and write-back. Accepts one instruction per handshake, performs naturally aligned byte, half, word (and double when XLEN=64) accesses over a request/grant/response data-memory port of arbitrary latency, and produces a write-back packet. Misalignment is reported as an exception, and the pipeline is stalled while an access is outstanding.

## Interface
Parameters:
- XLEN, 32, data width; legal values are 32 or 64.
- ADDR_W, 32, byte-address width.

Ports (clk, resetn: one clock; reset is synchronous and active-low):
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- in_valid  in  1  execute presents an instruction
- in_ready  out  1  stage can accept
- in_mem_op  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none)
- in_size  in  2  0 byte, 1 half, 2 word, 3 double
- in_unsigned  in  1  zero-extend load
- in_addr  in  ADDR_W  byte address
- in_wdata  in  XLEN  store data (low bytes significant)
- in_wb_data  in  XLEN  ALU result for non-memory ops
- in_wb_en  in  1  non-memory op writes rd
- in_rd  in  5  destination register
- in_pc  in  32  instruction PC
- dmem_req  out  1  memory request
- dmem_gnt  in  1  request accepted
- dmem_we  out  1  write
- dmem_addr  out  ADDR_W  address, low log2(XLEN/8) bits zero
- dmem_be  out  XLEN/8  byte enables
- dmem_wdata  out  XLEN  lane-steered store data
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read data
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_enable  out  1  write rd
- wb_addr  out  5  rd
- wb_data  out  XLEN  result
- wb_pc  out  32  PC
- exc_valid  out  1  exception accompanies wb_valid
- exc_cause  out  4  4 load misaligned, 6 store misaligned, 5 load access fault, 7 store access fault
- exc_tval  out  ADDR_W  faulting address
- stall  out  1  equals !in_ready

## Operation
- States: IDLE, REQ, RESP.
- IDLE: in_ready=1. On accept, the inputs are registered.
  - Non-memory op: retires next cycle; stays in IDLE.
  - Misaligned or illegal op: retires next cycle with exc_valid; no dmem access.
  - Otherwise goes to REQ.
- Misaligned: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0.
- Illegal: size=3 when XLEN=32 gives access fault (5 or 7).
- REQ: dmem_req=1 with stable we/addr/be/wdata until dmem_gnt.
  - Store with gnt: retires next cycle, wb_enable=0; goes to IDLE.
  - Load with gnt: goes to RESP.
- RESP: waits for dmem_rvalid. rdata is shifted right by 8×offset, then sign- or zero-extended per size/in_unsigned; retires next cycle; goes to IDLE.
- dmem_rvalid is ignored in IDLE and REQ. rvalid in the same cycle as gnt is not legal on the port.
- Store data is replicated across lanes; be = ((1<<2^size)−1) << offset.
- Load to rd=0: wb_enable=0. Exceptions: wb_enable=0, wb_data=0.
- Reset mid-operation: state goes to IDLE, dmem_req drops, and a late rvalid is discarded.

## Timing
- Reset values: in_ready=1, stall=0. All other outputs, including dmem_req, are 0.
- Accept at cycle T. Non-memory op or exception: wb_valid at T+1; back-to-back accepts give one retire per cycle.
- Memory op: dmem_req rises at T+1. Store retires at gnt cycle+1. Load retires at rvalid cycle+1.
- Zero-wait memory (gnt at T+1, rvalid at T+2): load wb_valid at T+3; next accept at T+3.
- in_ready=0 from T+1 until the retire cycle inclusive-1; it is high again in the retire cycle.
- All outputs are registered; the only combinational path is stall/in_ready from the state.

## Structure
- In rv32_pkg: lsu_op_t, lsu_size_t, lsu_state_t, and exception cause constants (CAUSE_LD_MISALIGN=4, CAUSE_LD_FAULT=5, CAUSE_ST_MISALIGN=6, CAUSE_ST_FAULT=7).
- Sub-module lsu_align: combinational XLEN-parametrised store lane steering / byte-enable generation and load extraction / extension, shared with future cache paths.

## Test plan
- XLEN=32, store byte 0xAB at 0x1003: dmem_be=4'b1000, wdata=0xABABABAB, addr=0x1000. Then load byte signed at 0x1003 with rdata=0xAB000000: wb_data=0xFFFFFFAB.
- Load half unsigned at 0x1002 with rdata=0x80010000: wb_data=0x00008001, wb_enable=1, rd preserved.
- Load word at 0x1001: no dmem_req; wb_valid at T+1 with exc_cause=4, exc_tval=0x1001.
- gnt delayed 3 cycles and rvalid 2 more: dmem fields stable while waiting, stall high throughout, wb_valid exactly once.
- XLEN=64, double load at 0x8 returns 0x0123456789ABCDEF. At XLEN=32, size=3 store gives exc_cause=7.
- Reset asserted in RESP, then rvalid arrives: no wb_valid, state IDLE, in_ready=1.
